opb_fwd_ctrl: RTL and testbench
===============================

Name: opb_fwd_ctrl

Overview:
- Controller for the ALU operand-B 4:1 select mux in the 16-bit pipelined RISC (stages IF/ID/EX/MEM/WB).
- Tracks destination registers of in-flight instructions in EX and MEM.
- Computes the registered operand-B select for the instruction entering EX.
- Raises load-use and distance-2 stalls and injects bubbles into EX.

Parameters:
REG_AW, 4, register address width (16 architectural registers)
ZERO_REG_EN, 1, when 1, register 0 never creates a hazard

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_hold  in  1  global freeze (memory wait); all state holds
flush  in  1  branch taken; kills ID instruction and EX slot
id_valid  in  1  valid instruction in ID
id_rs2  in  REG_AW  operand-B source register
id_use_imm  in  1  operand B is the immediate/address field
id_rd  in  REG_AW  destination register
id_reg_write  in  1  instruction writes id_rd
id_is_load  in  1  instruction is a load (result available after MEM)
stall  out  1  hold PC and IF/ID register (combinational)
ex_valid  out  1  EX slot holds a real instruction (registered)
ex_opb_sel  out  2  select for operand-B mux (registered)

Behaviour:
- Select encoding: 00 register file; 01 immediate/address; 10 forward from EX/MEM ALU result; 11 reserved, never driven (mux treats it as 00).
- Register file is write-through: a same-cycle WB write is readable in ID. Distance >=3 needs no action.
- Internal per-slot tracker for EX and MEM: {valid, rd, reg_write, is_load}.
- Reset (async, rst_n=0): both tracker slots invalid, ex_valid=0, ex_opb_sel=00, stall FSM in RUN, stall counter 0.
- Hazard match for a slot: slot.valid & slot.reg_write & slot.rd==id_rs2 & id_valid & !id_use_imm & !(ZERO_REG_EN & id_rs2==0).
- Decision for the ID instruction, in priority order:
  - id_use_imm -> sel 01.
  - EX-slot match and EX is a load -> stall, 2 cycles.
  - EX-slot match, not a load -> sel 10, no stall.
  - MEM-slot match (any type) -> stall, 1 cycle.
  - Otherwise -> sel 00.
- Stall FSM:
  - States: RUN, STALL.
  - RUN -> STALL on a stall decision; load counter with (cycles-1).
  - STALL: decrement the counter each unheld cycle; return to RUN when it reaches 0.
  - stall=1 combinationally in the first cycle of detection and throughout STALL.
  - Hazard logic is re-evaluated each cycle, so the cycle after a stall resolves to 00/10 correctly. Example: a load at distance 1 stalls 2 cycles, then reads the register file.
- Advance on each clk edge with pipe_hold=0:
  - MEM slot <= EX slot.
  - EX slot <= ID instruction if no stall, else bubble (valid=0).
  - ex_valid and ex_opb_sel are updated together with the EX slot.
  - A bubble drives ex_opb_sel=00.
- pipe_hold=1: every register and the FSM hold; stall output still reflects the current decision.
- flush=1 (unheld edge):
  - EX slot <= bubble; the MEM slot still advances.
  - FSM -> RUN, counter cleared.
  - flush overrides a stall in progress.
- Simultaneous flush and pipe_hold: hold wins; flush must be held until pipe_hold drops.
- Reset mid-stall: immediate return to reset values; no residual stall.
- Latency: select is registered, one cycle ID->EX. stall is zero-latency.

Decomposition:
- Shared package: OPB_SEL_REG=2'b00, OPB_SEL_IMM=2'b01, OPB_SEL_FWD=2'b10, and the tracker-slot struct {valid, rd, reg_write, is_load}.
- One sub-module is natural: opb_hazard_slot, one tracker pipeline register with hold/flush/bubble control, instantiated for EX and MEM.
- Hazard compare and FSM stay in the top level.

Test Plan:
- ADD r3 then ADD using rs2=r3 back-to-back -> stall=0; consumer enters EX with ex_opb_sel=10.
- LW r5 then ADD rs2=r5 -> stall=1 for 2 cycles; 2 bubbles (ex_valid=0); consumer enters EX with sel 00.
- ADD r4; unrelated; ADD rs2=r4 -> 1 stall cycle, then sel 00. ADDI with id_use_imm=1, rs2=r4 -> sel 01, no stall.
- Producer writes r0 then rs2=r0 with ZERO_REG_EN=1 -> no stall, sel 00. Repeat with ZERO_REG_EN=0 -> sel 10.
- LW r2, ADD rs2=r2, flush in the first stall cycle -> stall drops next cycle; EX bubble; FSM in RUN.
- pipe_hold=1 for 3 cycles during a load-use stall -> counter and tracker frozen; remaining stall completes after release. rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/opb_fwd_ctrl_pkg.sv
// opb_fwd_ctrl_pkg: operand-B select codes, tracker slot record and stall FSM states
package opb_fwd_ctrl_pkg;
  localparam logic [1:0] OPB_SEL_REG = 2'b00;
  localparam logic [1:0] OPB_SEL_IMM = 2'b01;
  localparam logic [1:0] OPB_SEL_FWD = 2'b10;
  // rd is sized for the widest register file supported; narrower addresses are zero-extended
  localparam int SLOT_RD_W = 8;
  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 reg_write;
    logic                 is_load;
  } slot_t;
  typedef enum logic {RUN, STALL} stall_st_t;
endpackage

// File: rtl/opb_hazard_slot.sv
// opb_hazard_slot: one in-flight tracker register with hold and bubble injection
module opb_hazard_slot
  import opb_fwd_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  kill,
  input  slot_t d,
  output slot_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (!hold) q <= kill ? '0 : d;
endmodule

// File: rtl/opb_fwd_ctrl.sv
// opb_fwd_ctrl: operand-B mux select, forwarding and load-use / distance-2 stall control
module opb_fwd_ctrl
  import opb_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_opb_sel
);
  slot_t ex_q, mem_q, id_slot;
  stall_st_t st, st_nx;
  logic cnt, cnt_nx;
  logic [SLOT_RD_W-1:0] rs2_x;
  logic id_src, match_ex, match_mem, load_use, mem_use;
  logic [1:0] id_sel;
  logic mem_is_load_unused;
  assign rs2_x = SLOT_RD_W'(id_rs2);
  assign id_src = id_valid & !id_use_imm & !(ZERO_REG_EN && id_rs2 == '0);
  assign match_ex = id_src & ex_q.valid & ex_q.reg_write & (ex_q.rd == rs2_x);
  assign match_mem = id_src & mem_q.valid & mem_q.reg_write & (mem_q.rd == rs2_x);
  assign load_use = match_ex & ex_q.is_load;
  assign mem_use = match_mem & !match_ex;
  assign mem_is_load_unused = mem_q.is_load;
  assign id_slot = '{valid: id_valid, rd: SLOT_RD_W'(id_rd), reg_write: id_reg_write, is_load: id_is_load};
  opb_hazard_slot u_ex (
    .clk(clk), .rst_n(rst_n), .hold(pipe_hold), .kill(flush | stall), .d(id_slot), .q(ex_q)
  );
  opb_hazard_slot u_mem (
    .clk(clk), .rst_n(rst_n), .hold(pipe_hold), .kill(1'b0), .d(ex_q), .q(mem_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= RUN;
      cnt <= 1'b0;
      ex_opb_sel <= OPB_SEL_REG;
    end else if (!pipe_hold) begin
      st <= st_nx;
      cnt <= cnt_nx;
      ex_opb_sel <= (flush | stall) ? OPB_SEL_REG : id_sel;
    end
  // counter holds the stall cycles still owed after the detection cycle
  always_comb begin
    cnt_nx = flush ? 1'b0 : (st == RUN) ? load_use : cnt - 1'b1;
    st_nx = (flush || cnt_nx == 1'b0) ? RUN : STALL;
  end
  always_comb begin
    stall = (st == STALL) | load_use | mem_use;
    id_sel = !id_valid ? OPB_SEL_REG : id_use_imm ? OPB_SEL_IMM : match_ex ? OPB_SEL_FWD : OPB_SEL_REG;
  end
  assign ex_valid = ex_q.valid;
endmodule

// File: tb/tb_opb_fwd_ctrl.sv
// tb_opb_fwd_ctrl: table-driven bench with an EX-stage scoreboard for opb_fwd_ctrl
module tb_opb_fwd_ctrl;
  typedef struct packed {
    logic       valid;
    logic [3:0] rs2;
    logic       imm;
    logic [3:0] rd;
    logic       rw;
    logic       ld;
    logic       hold;
    logic       flush;
    logic       es;
    logic       ev;
    logic [1:0] esel;
    logic [1:0] esel1;
  } vec_t;
  typedef struct packed {
    logic       ev;
    logic [1:0] sel;
    logic [1:0] sel1;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic pipe_hold = 1'b0, flush = 1'b0, id_valid = 1'b0, id_use_imm = 1'b0;
  logic id_reg_write = 1'b0, id_is_load = 1'b0;
  logic [3:0] id_rs2 = '0, id_rd = '0;
  logic stall0, stall1, exv0, exv1;
  logic [1:0] sel0, sel1;
  int checks = 0, fails = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  opb_fwd_ctrl #(.REG_AW(4), .ZERO_REG_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush(flush), .id_valid(id_valid),
    .id_rs2(id_rs2), .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .stall(stall0), .ex_valid(exv0), .ex_opb_sel(sel0)
  );
  opb_fwd_ctrl #(.REG_AW(4), .ZERO_REG_EN(1'b0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush(flush), .id_valid(id_valid),
    .id_rs2(id_rs2), .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .stall(stall1), .ex_valid(exv1), .ex_opb_sel(sel1)
  );

  function automatic vec_t v(logic va, logic [3:0] rs2, logic imm, logic [3:0] rd, logic rw,
                             logic ld, logic hold, logic fl, logic es, logic ev,
                             logic [1:0] esel, logic [1:0] esel1);
    return '{valid: va, rs2: rs2, imm: imm, rd: rd, rw: rw, ld: ld, hold: hold, flush: fl,
             es: es, ev: ev, esel: esel, esel1: esel1};
  endfunction

  task automatic chk(string name, int idx, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid = t.valid; id_rs2 = t.rs2; id_use_imm = t.imm; id_rd = t.rd;
    id_reg_write = t.rw; id_is_load = t.ld; pipe_hold = t.hold; flush = t.flush;
  endtask

  task automatic apply(vec_t t, int idx);
    exp_t e;
    drive(t);
    #1 chk("stall", idx, {1'b0, stall0}, {1'b0, t.es});
    sb.push_back('{ev: t.ev, sel: t.esel, sel1: t.esel1});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard [%0d]: got empty queue, expected an entry", idx);
    end else begin
      e = sb.pop_front();
      chk("ex_valid", idx, {1'b0, exv0}, {1'b0, e.ev});
      chk("ex_opb_sel", idx, sel0, e.sel);
      chk("ex_opb_sel_z0", idx, sel1, e.sel1);
    end
  endtask

  initial begin
    vec_t idle;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    // back-to-back ALU dependency forwards from EX/MEM
    vecs.push_back(v(1, 1, 0, 3, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 3, 0, 6, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10));
    vecs.push_back(idle); vecs.push_back(idle);
    // load-use: two bubbles then register file
    vecs.push_back(v(1, 1, 0, 5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(idle); vecs.push_back(idle);
    // distance-2 single stall, then immediate operand ignores a live hazard
    vecs.push_back(v(1, 1, 0, 4, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 1, 0, 8, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 4, 0, 9, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 4, 0, 9, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 1, 0, 4, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 4, 1, 10, 1, 0, 0, 0, 0, 1, 2'b01, 2'b01));
    vecs.push_back(idle); vecs.push_back(idle);
    // r0 producer: suppressed only when ZERO_REG_EN=1
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 0, 0, 11, 1, 0, 0, 0, 0, 1, 2'b00, 2'b10));
    vecs.push_back(idle); vecs.push_back(idle);
    // flush in first stall cycle
    vecs.push_back(v(1, 1, 0, 2, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 2, 0, 12, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 1, 0, 13, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(idle); vecs.push_back(idle);
    // pipe_hold freezes a load-use stall for three cycles
    vecs.push_back(v(1, 1, 0, 5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 5, 0, 7, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, 5, 0, 7, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(idle); vecs.push_back(idle);

    #1 rst_n = 1'b0;
    #1 chk("reset stall", 0, {1'b0, stall0}, 2'b00);
    chk("reset ex_valid", 0, {1'b0, exv0}, 2'b00);
    chk("reset ex_opb_sel", 0, sel0, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    foreach (vecs[i]) apply(vecs[i], i);

    // async reset during a held load-use stall clears everything at once
    apply(v(1, 1, 0, 5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00), 100);
    apply(v(1, 5, 0, 7, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00), 101);
    #1 chk("pre-reset stall", 102, {1'b0, stall0}, 2'b01);
    rst_n = 1'b0;
    #1 chk("mid-reset stall", 102, {1'b0, stall0}, 2'b00);
    chk("mid-reset ex_valid", 102, {1'b0, exv0}, 2'b00);
    chk("mid-reset ex_opb_sel", 102, sel0, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    apply(v(1, 5, 0, 7, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00), 103);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
